// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch port
// and the data (load/store) port, one transaction at a time.
// Optional feature macro: ARB_ROUND_ROBIN_EN (tie-break alternates owners);
// when undefined, data wins every tie (fixed priority).
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // fetch port
    input  logic                  if_req_i,
    input  logic [ADDR_W-1:0]     if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_W-1:0]     if_rdata_o,
    // data port
    input  logic                  d_req_i,
    input  logic [ADDR_W-1:0]     d_addr_i,
    input  logic [DATA_W/8-1:0]   d_we_i,
    input  logic [DATA_W-1:0]     d_wdata_i,
    output logic                  d_gnt_o,
    output logic                  d_rvalid_o,
    output logic [DATA_W-1:0]     d_rdata_o,
    // memory port
    output logic                  mem_req_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W/8-1:0]   mem_we_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_W-1:0]     mem_rdata_i,
    // status
    output logic                  prot_err_o,
    output logic [CNT_W-1:0]      conflict_cnt_o
);

    localparam int unsigned BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    state_e              state_q, state_d;

    // owner_q routes the response; it also serves as the round-robin history
    logic                owner_q, owner_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [BE_W-1:0]     mem_we_q, mem_we_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                if_gnt_q, if_gnt_d;
    logic                d_gnt_q, d_gnt_d;
    logic                if_rvalid_q, if_rvalid_d;
    logic                d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                prot_err_q, prot_err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                accept_c;
    logic                tie_pick_data_c;
    logic                pick_data_c;

    // Tie-break policy between simultaneous fetch and data requests
`ifdef ARB_ROUND_ROBIN_EN
    assign tie_pick_data_c = (owner_q == OWN_FETCH);
`else
    assign tie_pick_data_c = 1'b1;
`endif

    assign accept_c    = (state_q == ST_IDLE) && (if_req_i || d_req_i);
    assign pick_data_c = d_req_i && (!if_req_i || tie_pick_data_c);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (if_req_i || d_req_i) state_d = ST_REQ;
            ST_REQ:  if (mem_gnt_i)           state_d = ST_WAIT;
            ST_WAIT: if (mem_rvalid_i)        state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values; registered below
    always_comb begin
        owner_d     = owner_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        if_gnt_d    = 1'b0;
        d_gnt_d     = 1'b0;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        prot_err_d  = prot_err_q
                    | (mem_rvalid_i && (state_q != ST_WAIT))
                    | (mem_gnt_i    && (state_q != ST_REQ));
        cnt_d       = cnt_q;

        if ((state_q == ST_IDLE) && if_req_i && d_req_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    mem_req_d = 1'b1;
                    if (pick_data_c) begin
                        owner_d     = OWN_DATA;
                        mem_addr_d  = d_addr_i;
                        mem_we_d    = d_we_i;
                        mem_wdata_d = d_wdata_i;
                        d_gnt_d     = 1'b1;
                    end else begin
                        owner_d     = OWN_FETCH;
                        mem_addr_d  = if_addr_i;
                        mem_we_d    = '0;
                        mem_wdata_d = '0;
                        if_gnt_d    = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (mem_gnt_i) mem_req_d = 1'b0;
            end
            ST_WAIT: begin
                if (mem_rvalid_i) begin
                    if (owner_q == OWN_DATA) begin
                        d_rdata_d  = mem_rdata_i;
                        d_rvalid_d = 1'b1;
                    end else begin
                        if_rdata_d  = mem_rdata_i;
                        if_rvalid_d = 1'b1;
                    end
                end
            end
            default: begin
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q     <= OWN_DATA;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= '0;
            mem_wdata_q <= '0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            prot_err_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            owner_q     <= owner_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            prot_err_q  <= prot_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign if_gnt_o       = if_gnt_q;
    assign if_rvalid_o    = if_rvalid_q;
    assign if_rdata_o     = if_rdata_q;
    assign d_gnt_o        = d_gnt_q;
    assign d_rvalid_o     = d_rvalid_q;
    assign d_rdata_o      = d_rdata_q;
    assign mem_req_o      = mem_req_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_we_o       = mem_we_q;
    assign mem_wdata_o    = mem_wdata_q;
    assign prot_err_o     = prot_err_q;
    assign conflict_cnt_o = cnt_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares one single-ported, word-wide memory between the core's instruction-fetch port and its data (load/store) port. It sits between the RV32IM core and the unified memory. It accepts one request at a time, drives the memory handshake, and routes the response back to the owning requester. It also counts contention cycles for performance analysis.

## Interface
Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- CNT_W, 16, width of the contention counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  one-cycle pulse: fetch request accepted.
- if_rvalid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  DATA_W  fetch data.
- d_req  in  1  data request; held until d_gnt.
- d_addr  in  ADDR_W  data address.
- d_we  in  DATA_W/8  byte write enables; all-zero means a read.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  one-cycle pulse: data request accepted.
- d_rvalid  out  1  one-cycle pulse: load data valid, or store acknowledged.
- d_rdata  out  DATA_W  load data; unchanged raw word, no extension.
- mem_req  out  1  memory request; held until mem_gnt.
- mem_addr  out  ADDR_W  latched address.
- mem_we  out  DATA_W/8  latched byte enables; 0 for fetch.
- mem_wdata  out  DATA_W  latched store data.
- mem_gnt  in  1  memory accepts the request in this cycle.
- mem_rvalid  in  1  response or write-ack; at least 1 cycle after mem_gnt.
- mem_rdata  in  DATA_W  response data.
- prot_err  out  1  sticky error: memory protocol violation.
- conflict_cnt  out  CNT_W  saturating count of cycles with both requests pending in IDLE.

## Operation
- FSM states: IDLE, REQ, WAIT. Reset state is IDLE.
- IDLE:
  - If no request is pending, stay in IDLE.
  - Otherwise select the owner and latch its addr, we and wdata into the mem_* registers. For fetch, mem_we=0 and mem_wdata=0.
  - At the same edge, set mem_req=1, pulse the owner's gnt, and go to REQ.
- REQ: hold mem_req and the latched fields until mem_gnt=1. Then clear mem_req and go to WAIT.
- WAIT:
  - On mem_rvalid, register mem_rdata into the owner's rdata, pulse the owner's rvalid for 1 cycle, and go to IDLE.
  - The non-owner's rvalid stays 0.
- Requester obligations:
  - A requester holds req and its fields stable until it sees gnt.
  - Requests are sampled only in IDLE, so a req still high in the gnt cycle is not re-accepted.
- Owner selection:
  - When only one request is pending, that requester wins.
  - When both are pending, the winner is set by the policy in Configuration.
- prot_err is set and held until reset in either case:
  - mem_rvalid=1 while in IDLE or REQ. The response is dropped and the state is unchanged.
  - mem_gnt=1 outside REQ.
- conflict_cnt increments on every IDLE cycle with if_req and d_req both high. It saturates at all-ones; no wrap.
- Reset asserted mid-transaction:
  - All state clears asynchronously and the in-flight access is abandoned.
  - The memory must be reset by the same rst_n.

## Timing
- Reset values:
  - mem_req=0, mem_addr=0, mem_we=0, mem_wdata=0.
  - if_gnt=0, d_gnt=0, if_rvalid=0, d_rvalid=0, if_rdata=0, d_rdata=0.
  - prot_err=0, conflict_cnt=0, last_owner=DATA.
- All outputs are registered; there is no combinational path from inputs to outputs.
- With mem_gnt in the first REQ cycle and mem_rvalid one cycle later:
  - Request sampled at edge 0.
  - mem_req and gnt high in cycle 1.
  - mem_rvalid in cycle 2.
  - Requester rvalid in cycle 3.
  - Next arbitration at edge 3.
- Minimum spacing between back-to-back grants is 3 cycles.
- mem_rdata is captured only on mem_rvalid in WAIT. The rdata outputs hold their last value otherwise.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - On a tie, the winner is the requester that did not own the previous transaction.
  - last_owner updates at every grant. After reset, fetch wins the first tie.
- ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority: data always beats fetch, so the in-flight instruction's access completes first.
  - The last_owner register is not implemented.

## Test plan
- Lone fetch: if_req with if_addr=0x100, mem_gnt immediate, mem_rvalid one cycle later with 0x00500093 → if_gnt in cycle 1, mem_addr=0x100 with mem_we=0, if_rvalid with if_rdata=0x00500093 in cycle 3, d_rvalid stays 0.
- Lone store: d_addr=0x2004, d_we=4'b0011, d_wdata=0xDEADBEEF → mem_we=4'b0011 and mem_wdata=0xDEADBEEF; on ack, d_rvalid pulses once.
- Tie with ARB_ROUND_ROBIN_EN defined, both held continuously for 4 transactions → grant order fetch, data, fetch, data; conflict_cnt=4. With the macro undefined, data is granted every time both are pending.
- Memory stall: mem_gnt withheld for 5 cycles → mem_req and mem_addr stable for all 6 REQ cycles; exactly one gnt pulse.
- Protocol error: mem_rvalid pulsed while in IDLE → prot_err=1 and held, no rvalid to either requester; the next normal fetch still completes.
- Reset mid-WAIT: rst_n low for 1 cycle → all outputs return to reset values immediately; after release, a new request completes normally.
